scan_time_counter: RTL

Parametrised multi-digit mixed-radix time counter with an integrated multiplexed digit-scan driver. It generalises the fixed 4-digit minutes/seconds counter to N_DIGITS digits with per-digit radix, up/down mode, enable, parallel load and wrap carry-out. It sits between the board clock and the 7-segment decoder: sel/data feed the display, and value/carry_out feed other logic or cascaded counters.

---
 rtl/scan_counter_pkg.sv | 26 ++
 rtl/radix_digit_cell.sv | 50 +++++
 rtl/scan_time_counter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/scan_counter_pkg.sv
// Shared constants and helpers for the multiplexed mixed-radix time counter.
package scan_counter_pkg;

    localparam int DIGIT_W = 4;

    // Packed per-digit moduli and reset value, digit0 in the least significant nibble.
    localparam logic [4*DIGIT_W-1:0] DEFAULT_RADIX   = {4'd10, 4'd6, 4'd10, 4'd10};
    localparam logic [4*DIGIT_W-1:0] DEFAULT_RST_VAL = 16'h1234;

    // Forces an out-of-range digit to the largest legal value for its modulus.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input logic [DIGIT_W-1:0] modulus);
        return (d >= modulus) ? (modulus - 4'd1) : d;
    endfunction

    // Smallest width able to encode the highest sel code (N_DIGITS-1)*stride.
    function automatic int sel_width(input int n_digits, input int stride);
        int max_code;
        int w;
        max_code = (n_digits - 1) * stride;
        w = 1;
        while ((1 << w) <= max_code) w++;
        return w;
    endfunction

endpackage

// File: rtl/radix_digit_cell.sv
// One counter digit with a fixed modulus: wraps at the modulus on the way up,
// wraps to modulus-1 on the way down, and reports the wrap to the next digit.
module radix_digit_cell
    import scan_counter_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MODULUS   = 4'd10,
    parameter logic [DIGIT_W-1:0] RST_DIGIT = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               up_dn,
    input  logic               cin,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = MODULUS - 4'd1;

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;
    logic               at_limit;

    // The carry/borrow ripples combinationally so the whole chain settles in one cycle.
    assign at_limit = up_dn ? (digit_q == MAX_DIGIT) : (digit_q == '0);
    assign cout     = step & cin & at_limit;
    assign digit    = digit_q;

    // Next digit: load beats counting; count only when every lower digit wrapped.
    always_comb begin
        // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
        digit_d = digit_q;
        if (load) begin
            digit_d = clamp_digit(load_digit, MODULUS);
        end else if (step && cin) begin
            if (up_dn) digit_d = at_limit ? '0 : digit_q + 4'd1;
            else       digit_d = at_limit ? MAX_DIGIT : digit_q - 4'd1;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (rst) digit_q <= RST_DIGIT;
        else     digit_q <= digit_d;
    end

endmodule

// File: rtl/scan_time_counter.sv
// Mixed-radix up/down time counter with parallel load, wrap pulse and a
// multiplexed digit-scan driver feeding a 7-segment decoder.
module scan_time_counter
    import scan_counter_pkg::*;
#(
    parameter int                            N_DIGITS   = 4,
    parameter logic [DIGIT_W*N_DIGITS-1:0]   RADIX      = DEFAULT_RADIX,
    parameter logic [DIGIT_W*N_DIGITS-1:0]   RST_VAL    = DEFAULT_RST_VAL,
    parameter int                            TICK_DIV   = 10_000_000,
    parameter int                            SCAN_DIV   = 100_000,
    parameter int                            SEL_STRIDE = 2,
    parameter int                            SEL_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [DIGIT_W*N_DIGITS-1:0]   load_val,
    output logic [DIGIT_W*N_DIGITS-1:0]   value,
    output logic                          carry_out,
    output logic [SEL_W-1:0]              sel,
    output logic [DIGIT_W-1:0]            data
);

    localparam int TICK_CW = $clog2(TICK_DIV);
    localparam int SCAN_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [TICK_CW-1:0] TICK_LAST = TICK_CW'(TICK_DIV - 1);
    localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_DIGITS - 1);

    if (sel_width(N_DIGITS, SEL_STRIDE) > SEL_W) begin : g_sel_too_narrow
        $error("SEL_W cannot hold the highest sel code");
    end

    logic [TICK_CW-1:0] tick_q, tick_d;
    logic [SCAN_CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DIGIT_W-1:0] data_q, data_d;
    logic               carry_q, carry_d;
    logic               step;
    logic               wrap;
    logic [DIGIT_W-1:0] digit_arr [N_DIGITS];

    // Step pulse on the last enabled cycle of each tick period.
    assign step = en & (tick_q == TICK_LAST);

    // Digit chain: digit0 always sees a carry-in, higher digits see the wrap of the one below.
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        logic cin_w;
        logic cout_w;

        if (i == 0) begin : g_first
            assign cin_w = 1'b1;
        end else begin : g_next
            assign cin_w = g_digit[i-1].cout_w;
        end

        radix_digit_cell #(
            .MODULUS   (RADIX[i*DIGIT_W +: DIGIT_W]),
            .RST_DIGIT (RST_VAL[i*DIGIT_W +: DIGIT_W])
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .step       (step),
            .up_dn      (up_dn),
            .cin        (cin_w),
            .load       (load),
            .load_digit (load_val[i*DIGIT_W +: DIGIT_W]),
            .digit      (digit_arr[i]),
            .cout       (cout_w)
        );

        assign value[i*DIGIT_W +: DIGIT_W] = digit_arr[i];
    end

    assign wrap = g_digit[N_DIGITS-1].cout_w;

    // Tick divider and wrap pulse: held while disabled, restarted by a load.
    always_comb begin
        tick_d  = tick_q;
        carry_d = 1'b0;
        if (load) begin
            tick_d = '0;
        end else if (en) begin
            tick_d  = step ? '0 : tick_q + TICK_CW'(1);
            carry_d = wrap;
        end
    end

    // Scan driver: rotate through the digits, refreshing data from the live value every cycle.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_CW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        sel_d  = SEL_W'(int'(idx_d) * SEL_STRIDE);
        data_d = digit_arr[idx_d];
    end

    // Divider, scan and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= '0;
            carry_q    <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sel_q      <= '0;
            data_q     <= RST_VAL[DIGIT_W-1:0];
        end else begin
            tick_q     <= tick_d;
            carry_q    <= carry_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
        end
    end

    assign carry_out = carry_q;
    assign sel       = sel_q;
    assign data      = data_q;

endmodule
